keytone_ctrl: RTL and testbench
===============================

# keytone_ctrl

Parametrised keypad-to-tone controller. It sits between the debounced keypad scanner and the PWM audio generator, and converts a one-hot-or-more key vector into the period divisor N for the tone generator. It also provides:
- a programmable per-key note table,
- an octave shift,
- power on/off sequencing of the amplifier shutdown line,
- an optional release sustain.

## Interface
Parameters:
- NUM_KEYS, 16: width of the key vector and depth of the note table.
- N_W, 10: width of the period divisor N and of each table entry.
- OCT_MAX, 3: maximum octave shift; N is right-shifted by 0..OCT_MAX.
- HOLD_CYCLES, 1000000: sustain length in clk cycles; used only with KEYTONE_SUSTAIN_EN.

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- keys  in  NUM_KEYS  debounced key levels, bit i = key i held.
- on_off  in  1  single-cycle debounced toggle pulse.
- oct_up  in  1  single-cycle pulse; raises pitch by one octave.
- oct_dn  in  1  single-cycle pulse; lowers pitch by one octave.
- tbl_we  in  1  note table write strobe.
- tbl_addr  in  clog2(NUM_KEYS)  table entry to write.
- tbl_data  in  N_W  period divisor for that key.
- N  out  N_W  period divisor to the PWM generator; 0 = silent.
- shutdown_l  out  1  amplifier enable, active-low shutdown.
- note_valid  out  1  high while N carries a note.
- active_key  out  clog2(NUM_KEYS)  index of the key currently sounding.
- oct  out  clog2(OCT_MAX+1)  current octave shift.

## Operation
- States: OFF, IDLE, PLAY, SUSTAIN (SUSTAIN exists only with the macro).
- Reset:
  - state = IDLE;
  - N = 0, note_valid = 0, active_key = 0, oct = 0, shutdown_l = 1;
  - every table entry = 0.
- on_off pulse:
  - from any state other than OFF, go to OFF;
  - from OFF, go to IDLE.
  - on_off has priority over every other input in the same cycle.
- OFF:
  - N = 0, note_valid = 0, shutdown_l = 0;
  - keys are ignored;
  - oct and table writes still take effect.
- IDLE:
  - N = 0, shutdown_l = 1;
  - any keys bit set → PLAY.
- PLAY:
  - selected key = lowest set index in keys;
  - N = table[sel] >> oct, active_key = sel;
  - note_valid = 1 when the shifted value ≠ 0;
  - all keys released → SUSTAIN (macro) or IDLE.
- SUSTAIN:
  - N holds the last value;
  - a new key press → PLAY;
  - the counter reaches HOLD_CYCLES−1 → IDLE.
- Octave:
  - oct_up increments oct, saturating at OCT_MAX;
  - oct_dn decrements oct, saturating at 0;
  - both asserted in the same cycle: no change.
- Table:
  - tbl_we writes tbl_data to tbl_addr on the clock edge;
  - a write to the sounding key's entry appears on N on the following cycle;
  - tbl_addr ≥ NUM_KEYS is ignored.
- Arithmetic: the shift is a logical right shift truncated to N_W; no rounding.

## Timing
- Every output is registered.
- keys → N latency: 1 cycle; N changes on the edge after keys changes.
- on_off → shutdown_l and N: 1 cycle.
- oct pulse → N reflects the new shift: 2 cycles (oct is registered, then N).
- Table write → N: 2 cycles when the key is held.
- A key change during PLAY re-selects on the next edge, with no gap cycle of N = 0.
- Reset asserted mid-note: outputs return to their reset values on the next edge and the table is cleared.

## Configuration
- KEYTONE_SUSTAIN_EN defined:
  - SUSTAIN state and a sustain counter of clog2(HOLD_CYCLES) bits are compiled in;
  - on release, N holds for HOLD_CYCLES cycles, then goes to 0.
- KEYTONE_SUSTAIN_EN undefined:
  - no counter; PLAY goes straight to IDLE;
  - N = 0 one cycle after release;
  - HOLD_CYCLES is unused.

## Test plan
- Reset, write table[0] = 498 and table[7] = 444, press keys = 0x0081 → one cycle later N = 498 and active_key = 0; release bit 0 → N = 444, active_key = 7.
- oct_up ×2 while key 0 is held with table[0] = 498 → N = 249, then N = 124; a further oct_up ×2 with OCT_MAX = 3 → N = 62, then stays at 62.
- on_off pulse while key 0 is held → next cycle N = 0, shutdown_l = 0; second pulse → IDLE, shutdown_l = 1, and N = 498 one cycle after that.
- on_off, oct_up, oct_dn and a key edge all in the same cycle → state toggles to OFF, oct unchanged, N = 0.
- With KEYTONE_SUSTAIN_EN and HOLD_CYCLES = 8: release key 0 → N stays 498 for 8 cycles, then 0 with note_valid = 0; without the macro, N = 0 one cycle after release.
- Assert rst_n = 0 for one cycle during PLAY → N = 0, oct = 0, table cleared; pressing key 0 afterwards gives N = 0 and note_valid = 0.

Source files
------------

// File: rtl/keytone_ctrl.sv
// keytone_ctrl - keypad-to-tone controller.
//
// Converts a debounced key vector into the period divisor N for the PWM
// tone generator. The lowest-numbered held key wins. Each key's divisor comes
// from a writable note table, and N is then right-shifted by the current
// octave. A single on_off pulse toggles the amplifier power (shutdown_l).
//
// Optional feature: define KEYTONE_SUSTAIN_EN to keep the last note sounding
// for HOLD_CYCLES clocks after all keys are released. Without it, N drops to 0
// one cycle after release.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   keys                key levels, bit i = key i held
//   on_off              power toggle pulse (highest priority)
//   oct_up / oct_dn     octave shift pulses, saturating at 0..OCT_MAX
//   tbl_we/addr/data    note table write port
//   N                   period divisor, 0 = silent
//   shutdown_l          amplifier enable (low = shut down)
//   note_valid          N carries a non-zero note
//   active_key          index of the sounding key
//   oct                 current octave shift
module keytone_ctrl #(
    parameter int NUM_KEYS    = 16,
    parameter int N_W         = 10,
    parameter int OCT_MAX     = 3,
    parameter int HOLD_CYCLES = 1000000,
    localparam int AW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1,
    localparam int OW = (OCT_MAX > 0) ? $clog2(OCT_MAX + 1) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] keys,
    input  logic                on_off,
    input  logic                oct_up,
    input  logic                oct_dn,
    input  logic                tbl_we,
    input  logic [AW-1:0]       tbl_addr,
    input  logic [N_W-1:0]      tbl_data,
    output logic [N_W-1:0]      N,
    output logic                shutdown_l,
    output logic                note_valid,
    output logic [AW-1:0]       active_key,
    output logic [OW-1:0]       oct
);

    if (NUM_KEYS < 2 || OCT_MAX < 1 || HOLD_CYCLES < 1) begin : g_bad_params
        $error("keytone_ctrl: NUM_KEYS >= 2, OCT_MAX >= 1 and HOLD_CYCLES >= 1 are required");
    end

    typedef enum logic [1:0] {
        S_OFF,
        S_IDLE,
        S_PLAY
`ifdef KEYTONE_SUSTAIN_EN
        , S_SUSTAIN
`endif
    } state_t;

    state_t               state, state_nx;
    logic [N_W-1:0]       tbl [NUM_KEYS];
    logic [AW-1:0]        sel;
    logic                 any_key;
    logic [N_W-1:0]       n_d;
    logic                 nv_d;
    logic [AW-1:0]        ak_d;

`ifdef KEYTONE_SUSTAIN_EN
    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    logic [CW-1:0] cnt;
    logic          hold_done;
    assign hold_done = (cnt == CW'(HOLD_CYCLES - 1));
`endif

    // Lowest set index wins.
    always_comb begin
        sel     = '0;
        any_key = 1'b0;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            if (!any_key && keys[i]) begin
                sel     = AW'(i);
                any_key = 1'b1;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            N          <= '0;
            note_valid <= 1'b0;
            active_key <= '0;
            shutdown_l <= 1'b1;
        end else begin
            state      <= state_nx;
            N          <= n_d;
            note_valid <= nv_d;
            active_key <= ak_d;
            shutdown_l <= (state_nx != S_OFF);
        end
    end

    // Next-state logic; on_off overrides everything else.
    always_comb begin
        state_nx = state;
        if (on_off) begin
            state_nx = (state == S_OFF) ? S_IDLE : S_OFF;
        end else begin
            case (state)
                S_OFF:  state_nx = S_OFF;
                S_IDLE: if (any_key) state_nx = S_PLAY;
                S_PLAY: begin
                    if (!any_key) begin
`ifdef KEYTONE_SUSTAIN_EN
                        state_nx = S_SUSTAIN;
`else
                        state_nx = S_IDLE;
`endif
                    end
                end
`ifdef KEYTONE_SUSTAIN_EN
                S_SUSTAIN: begin
                    if (any_key)        state_nx = S_PLAY;
                    else if (hold_done) state_nx = S_IDLE;
                end
`endif
                default: state_nx = S_IDLE;
            endcase
        end
    end

    // Output next-values are derived from the next state so every output
    // settles on the same edge as the state change (1-cycle latency).
    always_comb begin
        n_d  = N;
        nv_d = note_valid;
        ak_d = active_key;
        case (state_nx)
            S_PLAY: begin
                n_d  = tbl[sel] >> oct;
                nv_d = (n_d != '0);
                ak_d = sel;
            end
`ifdef KEYTONE_SUSTAIN_EN
            S_SUSTAIN: begin
                n_d  = N;
                nv_d = note_valid;
            end
`endif
            default: begin
                n_d  = '0;
                nv_d = 1'b0;
            end
        endcase
    end

    // Octave and note table; both keep working while powered off, but an
    // on_off pulse masks them for its cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            oct <= '0;
            for (int unsigned i = 0; i < NUM_KEYS; i++) tbl[i] <= '0;
        end else if (!on_off) begin
            if (oct_up && !oct_dn && oct != OW'(OCT_MAX)) oct <= oct + 1'b1;
            if (oct_dn && !oct_up && oct != '0)           oct <= oct - 1'b1;
            if (tbl_we && 32'(tbl_addr) < NUM_KEYS)       tbl[tbl_addr] <= tbl_data;
        end
    end

`ifdef KEYTONE_SUSTAIN_EN
    // Counts sustain cycles; restarts on every entry into SUSTAIN.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (state == S_SUSTAIN && state_nx == S_SUSTAIN) begin
            cnt <= cnt + 1'b1;
        end else begin
            cnt <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_keytone_ctrl.sv
module tb_keytone_ctrl;

    localparam int NK   = 16;
    localparam int NW   = 10;
    localparam int OMAX = 3;
    localparam int HOLD = 8;
`ifdef KEYTONE_SUSTAIN_EN
    localparam bit SUS = 1'b1;
`else
    localparam bit SUS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NK-1:0] keys;
    logic          on_off, oct_up, oct_dn, tbl_we;
    logic [3:0]    tbl_addr;
    logic [NW-1:0] tbl_data;
    logic [NW-1:0] N;
    logic          shutdown_l, note_valid;
    logic [3:0]    active_key;
    logic [1:0]    oct;

    keytone_ctrl #(
        .NUM_KEYS(NK), .N_W(NW), .OCT_MAX(OMAX), .HOLD_CYCLES(HOLD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .keys(keys), .on_off(on_off),
        .oct_up(oct_up), .oct_dn(oct_dn), .tbl_we(tbl_we),
        .tbl_addr(tbl_addr), .tbl_data(tbl_data), .N(N),
        .shutdown_l(shutdown_l), .note_valid(note_valid),
        .active_key(active_key), .oct(oct)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: power flag, "a note is held" flag, sustain countdown.
    bit m_power, m_play;
    int m_left, m_oct;
    int m_tbl [NK];
    int eN, eV, eAK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model(input bit r, input logic [NK-1:0] k, input bit oo,
                         input bit up, input bit dn, input bit we,
                         input int addr, input int data);
        int s, v;
        if (!r) begin
            m_power = 1; m_play = 0; m_left = 0; m_oct = 0;
            foreach (m_tbl[i]) m_tbl[i] = 0;
            eN = 0; eV = 0; eAK = 0;
        end else if (oo) begin
            m_power = !m_power; m_play = 0; m_left = 0; eN = 0; eV = 0;
        end else begin
            if (!m_power) begin
                eN = 0; eV = 0;
            end else if (k != 0) begin
                s = 0;
                for (int i = 0; i < NK; i++) if (k[i]) begin s = i; break; end
                v = m_tbl[s] >> m_oct;
                eN = v; eV = (v != 0) ? 1 : 0; eAK = s;
                m_play = 1; m_left = 0;
            end else if (SUS && m_play) begin
                m_play = 0; m_left = HOLD;      // this release cycle counts as the first held one
            end else if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin eN = 0; eV = 0; end
            end else begin
                m_play = 0; eN = 0; eV = 0;
            end
            if (up && !dn && m_oct < OMAX) m_oct++;
            if (dn && !up && m_oct > 0)    m_oct--;
            if (we && addr < NK) m_tbl[addr] = data;
        end
    endtask

    task automatic step(input bit r, input logic [NK-1:0] k, input bit oo = 0,
                        input bit up = 0, input bit dn = 0, input bit we = 0,
                        input int addr = 0, input int data = 0);
        rst_n = r; keys = k; on_off = oo; oct_up = up; oct_dn = dn;
        tbl_we = we; tbl_addr = 4'(addr); tbl_data = NW'(data);
        @(posedge clk);
        #1;
        model(r, k, oo, up, dn, we, addr, data);
        chk("N", 32'(N), 32'(eN));
        chk("note_valid", 32'(note_valid), 32'(eV));
        chk("shutdown_l", 32'(shutdown_l), 32'(m_power));
        chk("oct", 32'(oct), 32'(m_oct));
        chk("active_key", 32'(active_key), 32'(eAK));
    endtask

    initial begin
        logic [NK-1:0] k;
        m_power = 1; m_play = 0; m_left = 0; m_oct = 0; eN = 0; eV = 0; eAK = 0;
        foreach (m_tbl[i]) m_tbl[i] = 0;
        k = '0;

        // Reset state
        step(0, 16'h0);
        step(0, 16'h0);
        chk("rst_N", 32'(N), 0);
        chk("rst_shutdown", 32'(shutdown_l), 1);

        // Table writes and lowest-key selection
        step(1, 16'h0, 0, 0, 0, 1, 0, 498);
        step(1, 16'h0, 0, 0, 0, 1, 7, 444);
        step(1, 16'h0081);
        chk("tp_sel0_N", 32'(N), 498);
        chk("tp_sel0_ak", 32'(active_key), 0);
        step(1, 16'h0080);
        chk("tp_sel7_N", 32'(N), 444);
        chk("tp_sel7_ak", 32'(active_key), 7);

        // Octave shifts up to saturation, then back down
        step(1, 16'h0001);
        step(1, 16'h0001, 0, 1);
        step(1, 16'h0001, 0, 1);
        chk("tp_oct1", 32'(N), 249);
        step(1, 16'h0001);
        chk("tp_oct2", 32'(N), 124);
        step(1, 16'h0001, 0, 1);
        step(1, 16'h0001, 0, 1);
        chk("tp_oct3", 32'(N), 62);
        step(1, 16'h0001);
        chk("tp_oct_sat", 32'(N), 62);
        chk("tp_oct_sat_oct", 32'(oct), 3);
        step(1, 16'h0001, 0, 0, 1);
        step(1, 16'h0001, 0, 0, 1);
        step(1, 16'h0001, 0, 0, 1);
        step(1, 16'h0001);
        chk("tp_oct0", 32'(N), 498);

        // Power toggling with a key held
        step(1, 16'h0001, 1);
        chk("tp_off_N", 32'(N), 0);
        chk("tp_off_sd", 32'(shutdown_l), 0);
        step(1, 16'h0001);
        step(1, 16'h0001, 1);
        chk("tp_on_sd", 32'(shutdown_l), 1);
        chk("tp_on_N", 32'(N), 0);
        step(1, 16'h0001);
        chk("tp_on_play", 32'(N), 498);

        // on_off together with both octave pulses and a key edge
        step(1, 16'h0003, 1, 1, 1);
        chk("tp_prio_N", 32'(N), 0);
        chk("tp_prio_oct", 32'(oct), 0);
        chk("tp_prio_sd", 32'(shutdown_l), 0);
        step(1, 16'h0003, 1);

        // Release behaviour
        step(1, 16'h0001);
        step(1, 16'h0000);
        if (!SUS) chk("tp_release", 32'(N), 0);
        for (int i = 0; i < HOLD + 3; i++) step(1, 16'h0000);
        chk("tp_release_end", 32'(N), 0);
        chk("tp_release_nv", 32'(note_valid), 0);

        // Reset mid-note clears the table
        step(1, 16'h0001);
        step(0, 16'h0001);
        step(1, 16'h0001);
        chk("tp_rst_N", 32'(N), 0);
        chk("tp_rst_nv", 32'(note_valid), 0);

        // Randomised traffic against the model
        for (int c = 0; c < 600; c++) begin
            bit r, oo, up, dn, we;
            case ($urandom_range(0, 3))
                0: k = '0;
                1: k = NK'(1) << $urandom_range(0, NK - 1);
                2: k = NK'($urandom);
                default: ;
            endcase
            r  = ($urandom_range(0, 149) != 0);
            oo = ($urandom_range(0, 24) == 0);
            up = ($urandom_range(0, 5) == 0);
            dn = ($urandom_range(0, 5) == 0);
            we = ($urandom_range(0, 3) == 0);
            step(r, k, oo, up, dn, we, int'($urandom_range(0, NK - 1)),
                 int'($urandom_range(0, (1 << NW) - 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
